// File: rtl/game_mem_arbiter.sv
// Single-port arbiter/sequencer for the 16x8 game memory shared by keyboard, game-logic and display.
// Define GAME_MEM_ARB_RR_EN for round-robin arbitration (kb -> gl -> dp); default is fixed gl > kb > dp.
module game_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              kb_req,
  input  logic [ADDR_W-1:0] kb_addr,
  input  logic [DATA_W-1:0] kb_wdata,
  output logic              kb_gnt,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic              gl_lock,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [DATA_W-1:0] gl_wdata,
  output logic              gl_gnt,
  output logic              gl_rvalid,
  output logic [DATA_W-1:0] gl_rdata,
  input  logic              dp_req,
  input  logic [ADDR_W-1:0] dp_addr,
  output logic              dp_gnt,
  output logic              dp_rvalid,
  output logic [DATA_W-1:0] dp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {
    OWN_KB   = 2'd0,
    OWN_GL   = 2'd1,
    OWN_DP   = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  state_t            state;
  owner_t            owner;
  owner_t            last_owner;
  owner_t            win;
  logic              we_q;
  logic [DATA_W-1:0] gl_rdata_q;
  logic [DATA_W-1:0] dp_rdata_q;
  logic              lock_active;
  logic              elig_kb;
  logic              elig_gl;
  logic              elig_dp;
  logic              any_req;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

`ifdef GAME_MEM_ARB_RR_EN
  owner_t rr_ptr;

  function automatic owner_t next_owner(input owner_t o);
    case (o)
      OWN_KB:  return OWN_GL;
      OWN_GL:  return OWN_DP;
      default: return OWN_KB;
    endcase
  endfunction
`endif

  // Lock keeps the memory for game-logic between its read and the follow-up clear.
  always_comb begin
    lock_active = gl_lock && (last_owner == OWN_GL);
    elig_kb     = kb_req && !lock_active;
    elig_gl     = gl_req;
    elig_dp     = dp_req && !lock_active;
    any_req     = elig_kb || elig_gl || elig_dp;
    win         = OWN_NONE;
`ifdef GAME_MEM_ARB_RR_EN
    case (rr_ptr)
      OWN_GL: begin
        if (elig_gl)      win = OWN_GL;
        else if (elig_dp) win = OWN_DP;
        else if (elig_kb) win = OWN_KB;
      end
      OWN_DP: begin
        if (elig_dp)      win = OWN_DP;
        else if (elig_kb) win = OWN_KB;
        else if (elig_gl) win = OWN_GL;
      end
      default: begin
        if (elig_kb)      win = OWN_KB;
        else if (elig_gl) win = OWN_GL;
        else if (elig_dp) win = OWN_DP;
      end
    endcase
`else
    if (elig_gl)      win = OWN_GL;
    else if (elig_kb) win = OWN_KB;
    else if (elig_dp) win = OWN_DP;
`endif
  end

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    case (win)
      OWN_KB: begin
        win_we    = 1'b1;
        win_addr  = kb_addr;
        win_wdata = kb_wdata;
      end
      OWN_GL: begin
        win_we    = gl_we;
        win_addr  = gl_addr;
        win_wdata = gl_wdata;
      end
      OWN_DP: begin
        win_addr  = dp_addr;
      end
      default: begin
        win_we    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      last_owner <= OWN_NONE;
      we_q       <= 1'b0;
      kb_gnt     <= 1'b0;
      gl_gnt     <= 1'b0;
      dp_gnt     <= 1'b0;
      gl_rvalid  <= 1'b0;
      dp_rvalid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      gl_rdata_q <= '0;
      dp_rdata_q <= '0;
      busy       <= 1'b0;
`ifdef GAME_MEM_ARB_RR_EN
      rr_ptr     <= OWN_KB;
`endif
    end else begin
      kb_gnt    <= 1'b0;
      gl_gnt    <= 1'b0;
      dp_gnt    <= 1'b0;
      gl_rvalid <= 1'b0;
      dp_rvalid <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            owner      <= win;
            last_owner <= win;
            we_q       <= win_we;
            mem_we     <= win_we;
            mem_addr   <= win_addr;
            mem_wdata  <= win_wdata;
            kb_gnt     <= (win == OWN_KB);
            gl_gnt     <= (win == OWN_GL);
            dp_gnt     <= (win == OWN_DP);
`ifdef GAME_MEM_ARB_RR_EN
            rr_ptr     <= next_owner(win);
`endif
          end
        end
        ACCESS: begin
          if (we_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= RESP;
            gl_rvalid <= (owner == OWN_GL);
            dp_rvalid <= (owner == OWN_DP);
          end
        end
        RESP: begin
          if (owner == OWN_GL) gl_rdata_q <= mem_rdata;
          if (owner == OWN_DP) dp_rdata_q <= mem_rdata;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory data arrives during RESP; bypass it so rdata is valid alongside rvalid.
  assign gl_rdata = (state == RESP && owner == OWN_GL) ? mem_rdata : gl_rdata_q;
  assign dp_rdata = (state == RESP && owner == OWN_DP) ? mem_rdata : dp_rdata_q;

endmodule

// File: tb/tb_game_mem_arbiter.sv
// Directed bench for game_mem_arbiter with a registered-read memory model attached.
module tb_game_mem_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       kb_req;
  logic [3:0] kb_addr;
  logic [7:0] kb_wdata;
  logic       kb_gnt;
  logic       gl_req;
  logic       gl_we;
  logic       gl_lock;
  logic [3:0] gl_addr;
  logic [7:0] gl_wdata;
  logic       gl_gnt;
  logic       gl_rvalid;
  logic [7:0] gl_rdata;
  logic       dp_req;
  logic [3:0] dp_addr;
  logic       dp_gnt;
  logic       dp_rvalid;
  logic [7:0] dp_rdata;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [16];
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  game_mem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .kb_req(kb_req), .kb_addr(kb_addr), .kb_wdata(kb_wdata), .kb_gnt(kb_gnt),
    .gl_req(gl_req), .gl_we(gl_we), .gl_lock(gl_lock), .gl_addr(gl_addr),
    .gl_wdata(gl_wdata), .gl_gnt(gl_gnt), .gl_rvalid(gl_rvalid), .gl_rdata(gl_rdata),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid),
    .dp_rdata(dp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Memory model: registered read data, one cycle after the address.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
      mem_ready <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    kb_req = 1'b0; kb_addr = 4'd0; kb_wdata = 8'h00;
    gl_req = 1'b0; gl_we = 1'b0; gl_lock = 1'b0; gl_addr = 4'd0; gl_wdata = 8'h00;
    dp_req = 1'b0; dp_addr = 4'd0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_gnts", {kb_gnt, gl_gnt, dp_gnt}, 0);
    check("rst_rvalids", {gl_rvalid, dp_rvalid, mem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", {gl_rdata, dp_rdata, mem_wdata}, 0);
    rstn = 1'b1;

    // kb write addr 3 = 0x15, then dp read addr 3
    kb_req = 1'b1; kb_addr = 4'd3; kb_wdata = 8'h15;
    tick();
    check("t1_kb_gnt", kb_gnt, 1);
    check("t1_mem_we", mem_we, 1);
    check("t1_mem_addr", mem_addr, 3);
    check("t1_mem_wdata", mem_wdata, 8'h15);
    check("t1_busy", busy, 1);
    kb_req = 1'b0;
    tick();
    check("t1_kb_gnt_pulse", kb_gnt, 0);
    check("t1_busy_idle", busy, 0);
    dp_req = 1'b1; dp_addr = 4'd3;
    tick();
    check("t1_dp_gnt", dp_gnt, 1);
    check("t1_read_we", mem_we, 0);
    dp_req = 1'b0;
    tick();
    check("t1_dp_rvalid", dp_rvalid, 1);
    check("t1_dp_rdata", dp_rdata, 8'h15);
    tick();
    check("t1_dp_rvalid_pulse", dp_rvalid, 0);
    check("t1_dp_rdata_hold", dp_rdata, 8'h15);

    // simultaneous requests on addr 0 from a fresh reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    kb_req = 1'b1; kb_addr = 4'd0; kb_wdata = 8'h01;
    gl_req = 1'b1; gl_we = 1'b0; gl_addr = 4'd0;
    dp_req = 1'b1; dp_addr = 4'd0;
`ifdef GAME_MEM_ARB_RR_EN
    tick();
    check("t2_rr_first_kb", {kb_gnt, gl_gnt, dp_gnt}, 3'b100);
    kb_req = 1'b0;
    tick(); tick();
    check("t2_rr_second_gl", {kb_gnt, gl_gnt, dp_gnt}, 3'b010);
    gl_req = 1'b0;
    tick();
    check("t2_rr_gl_rvalid", gl_rvalid, 1);
    check("t2_rr_gl_rdata", gl_rdata, 8'h01);
    tick(); tick();
    check("t2_rr_third_dp", {kb_gnt, gl_gnt, dp_gnt}, 3'b001);
    dp_req = 1'b0;
    tick();
`else
    tick();
    check("t2_first_gl", {kb_gnt, gl_gnt, dp_gnt}, 3'b010);
    gl_req = 1'b0;
    tick();
    check("t2_gl_rvalid", gl_rvalid, 1);
    check("t2_gl_rdata_old", gl_rdata, 8'h00);
    tick(); tick();
    check("t2_second_kb", {kb_gnt, gl_gnt, dp_gnt}, 3'b100);
    check("t2_kb_mem_we", mem_we, 1);
    kb_req = 1'b0;
    tick(); tick();
    check("t2_third_dp", {kb_gnt, gl_gnt, dp_gnt}, 3'b001);
    dp_req = 1'b0;
    tick();
`endif
    check("t2_dp_rvalid", dp_rvalid, 1);
    check("t2_dp_rdata_new", dp_rdata, 8'h01);
    tick();

    // locked read-then-clear of addr 5 while dp waits
    kb_req = 1'b1; kb_addr = 4'd5; kb_wdata = 8'h5A;
    tick();
    check("t3_kb_gnt", kb_gnt, 1);
    kb_req = 1'b0;
    tick();
    gl_req = 1'b1; gl_we = 1'b0; gl_lock = 1'b1; gl_addr = 4'd5;
    dp_req = 1'b1; dp_addr = 4'd5;
    tick();
    check("t3_gl_gnt", {gl_gnt, dp_gnt}, 2'b10);
    gl_req = 1'b0;
    tick();
    check("t3_gl_rvalid", gl_rvalid, 1);
    check("t3_gl_rdata", gl_rdata, 8'h5A);
    tick();
    check("t3_locked_dp_a", {dp_gnt, busy}, 2'b00);
    tick();
    check("t3_locked_dp_b", {dp_gnt, busy}, 2'b00);
    gl_req = 1'b1; gl_we = 1'b1; gl_wdata = 8'h00;
    tick();
    check("t3_clear_gnt", {gl_gnt, mem_we}, 2'b11);
    check("t3_clear_addr", mem_addr, 5);
    check("t3_clear_wdata", mem_wdata, 8'h00);
    gl_req = 1'b0;
    tick();
    check("t3_locked_dp_c", dp_gnt, 0);
    tick();
    check("t3_locked_dp_d", {dp_gnt, busy}, 2'b00);
    gl_lock = 1'b0;
    tick();
    check("t3_dp_gnt_after_unlock", dp_gnt, 1);
    check("t3_dp_addr", mem_addr, 5);
    dp_req = 1'b0;
    tick();
    check("t3_dp_rvalid", dp_rvalid, 1);
    check("t3_dp_rdata_cleared", dp_rdata, 8'h00);
    tick();

    // reset during RESP of a dp read aborts it
    dp_req = 1'b1; dp_addr = 4'd3;
    tick();
    check("t4_dp_gnt", dp_gnt, 1);
    dp_req = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("t4_abort_rvalid", dp_rvalid, 0);
    check("t4_abort_rdata", dp_rdata, 8'h00);
    check("t4_abort_busy", busy, 0);
    tick();
    rstn = 1'b1;
    tick();
    check("t4_no_late_rvalid", {dp_rvalid, dp_gnt, busy}, 3'b000);
    dp_req = 1'b1;
    tick();
    check("t4_retry_gnt", dp_gnt, 1);
    dp_req = 1'b0;
    tick();
    check("t4_retry_rvalid", dp_rvalid, 1);
    check("t4_retry_rdata", dp_rdata, 8'h15);
    tick();

`ifndef GAME_MEM_ARB_RR_EN
    // kb streams 4 writes back to back while dp waits
    kb_req = 1'b1; kb_addr = 4'd8; kb_wdata = 8'hA0;
    dp_req = 1'b1; dp_addr = 4'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_kb_gnt", {kb_gnt, dp_gnt}, 2'b10);
      check("t5_kb_addr", mem_addr, 8 + i);
      if (i < 3) begin
        kb_addr  = kb_addr + 4'd1;
        kb_wdata = kb_wdata + 8'h01;
        tick();
        check("t5_gap", {kb_gnt, dp_gnt, busy}, 3'b000);
      end else begin
        kb_req = 1'b0;
      end
    end
    tick();
    check("t5_busy_drop", {busy, dp_gnt}, 2'b00);
    tick();
    check("t5_dp_gnt", dp_gnt, 1);
    check("t5_dp_addr", mem_addr, 9);
    dp_req = 1'b0;
    tick();
    check("t5_dp_rvalid", dp_rvalid, 1);
    check("t5_dp_rdata", dp_rdata, 8'hA1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_mem_arbiter.md
# game_mem_arbiter

Single-port access arbiter and sequencer for the 16×8 game memory. Three requesters share the memory through this block: the keyboard loader (writes), the game-logic scan/clear engine (reads and writes), and the display readback scanner (reads). It serialises their accesses, drives the memory port, and returns read data with a valid pulse. It sits between `keyboard_ctrl`, `game_logic`, the display path and `game_mem` in `top`.

## Interface
- `ADDR_W`, 4, memory address width (16 entries)
- `DATA_W`, 8, memory data width

- `clk`  in  1  system clock; all logic on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `kb_req`  in  1  keyboard write request; held until `kb_gnt`
- `kb_addr`  in  ADDR_W  keyboard write address
- `kb_wdata`  in  DATA_W  keyboard write data
- `kb_gnt`  out  1  one-cycle pulse: keyboard write performed
- `gl_req`  in  1  game-logic request; held until `gl_gnt`
- `gl_we`  in  1  1 = write, 0 = read
- `gl_lock`  in  1  while high, the memory is reserved for game-logic after its grant
- `gl_addr`  in  ADDR_W  game-logic address
- `gl_wdata`  in  DATA_W  game-logic write data (clear = 0x00)
- `gl_gnt`  out  1  one-cycle pulse: access issued to memory
- `gl_rvalid`  out  1  one-cycle pulse: `gl_rdata` valid
- `gl_rdata`  out  DATA_W  read data, held until the next game-logic read
- `dp_req`  in  1  display read request; held until `dp_gnt`
- `dp_addr`  in  ADDR_W  display read address
- `dp_gnt`  out  1  one-cycle pulse: read issued
- `dp_rvalid`  out  1  one-cycle pulse: `dp_rdata` valid
- `dp_rdata`  out  DATA_W  read data, held until the next display read
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, registered, 1-cycle latency after address
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any eligible request is present, select the winner.
  - Latch the winner's owner ID, `we`, addr and wdata (keyboard `we` = 1, display `we` = 0).
  - Go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - `mem_we` = latched `we`.
  - Assert the owner's `*_gnt` for exactly this cycle.
  - Next state: IDLE for a write, RESP for a read.
- RESP:
  - Capture `mem_rdata` into the owner's rdata register.
  - Pulse the owner's `*_rvalid` for one cycle.
  - Go to IDLE.
- Default arbitration is fixed priority: gl > kb > dp.
- Lock:
  - If `gl_lock` = 1 and the last completed owner was game-logic, only `gl_req` is eligible in IDLE.
  - The lock is released when `gl_lock` falls. This makes read-compare-clear atomic.
- `mem_addr` and `mem_wdata` always drive the latched values. `mem_we` is high only in ACCESS for a write.
- A request dropped after it has been latched still completes, and its gnt/rvalid still pulse.
- A requester that keeps `req` high after `gnt` is treated as a new request.
- Reset mid-transaction: the transaction is aborted; no gnt or rvalid is emitted.

## Timing
- Reset values:
  - state IDLE
  - all `*_gnt`, `*_rvalid`, `mem_we`, `busy` = 0
  - `mem_addr`, `mem_wdata`, `gl_rdata`, `dp_rdata` = 0
  - last-owner = none; RR pointer = kb
- Request sampled in IDLE at edge N: gnt (and `mem_we` for writes) is high in cycle N+1.
- Read: rvalid is high in cycle N+2, and rdata is valid from that cycle.
- Throughput:
  - Write: 2 cycles per access. The next grant can follow 2 cycles after the previous grant.
  - Read: 3 cycles per access.
- Simultaneous requests are resolved in the same IDLE cycle. Losers wait, with no starvation guarantee in fixed-priority mode.

## Configuration
- Macro: `GAME_MEM_ARB_RR_EN`.
- Defined:
  - Round-robin among the eligible requesters, in the order kb → gl → dp.
  - Starting point = the requester after the last granted one.
  - The pointer advances on each ACCESS.
  - Lock rules still override.
- Undefined:
  - Fixed priority gl > kb > dp.
  - No pointer register.

## Test plan
- Reset, then kb write addr 3 data 0x15, then dp read addr 3:
  - `kb_gnt` pulses 1 cycle after the request, with `mem_we` = 1 in that cycle.
  - `dp_rvalid` pulses 2 cycles after `dp_req` is sampled, with `dp_rdata` = 0x15.
- Simultaneous kb (addr 0, 0x01), gl read addr 0, dp read addr 0:
  - Fixed priority: grants in the order gl, kb, dp. gl reads the old value 0x00, dp reads 0x01.
  - With `GAME_MEM_ARB_RR_EN` from reset: order kb, gl, dp.
- gl read addr 5 with `gl_lock` = 1, gl write 0x00 to addr 5, `dp_req` held throughout:
  - dp is not granted until `gl_lock` falls.
  - dp then reads 0x00.
- dp read granted, then `rstn` asserted during RESP:
  - No `dp_rvalid`; `dp_rdata` = 0; `busy` = 0.
  - After release, a new dp read completes normally.
- kb holds `kb_req` continuously for 4 writes while dp requests (fixed priority):
  - `kb_gnt` pulses every 2 cycles.
  - dp is granted only after kb drops its request.
  - `busy` deasserts 1 cycle after the final ACCESS.
